// File: rtl/cnn_pkg.sv
// Constants and loader state type shared by the CNN input loader and the inference engine.
package cnn_pkg;

  localparam int CNN_DATA_W = 7;
  localparam int CNN_ADDR_W = 12;
  localparam int CNN_N_PIX  = 400;
  localparam logic [CNN_DATA_W-1:0] CNN_BIAS_VAL = 7'h40;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BIAS,
    HOLD,
    DRAIN
  } loader_state_t;

endpackage

// File: rtl/cnn_input_loader.sv
// Writer side of the CNN input-feature RAM: streams quantized pixels, appends the bias word, holds until acked.
// Optional LOADER_CKSUM_EN adds a 16-bit running checksum output of the words written for the current image.
module cnn_input_loader
  import cnn_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DATA_W = CNN_DATA_W,
  parameter int ADDR_W = CNN_ADDR_W,
  parameter int N_PIX  = CNN_N_PIX,
  parameter logic [DATA_W-1:0] BIAS_VAL = DATA_W'(CNN_BIAS_VAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              img_ready,
  input  logic              infer_ack,
  output logic              err_len,
  output logic [15:0]       frame_cnt
`ifdef LOADER_CKSUM_EN
  ,
  output logic [15:0]       cksum
`endif
);

  localparam int CNT_W = $clog2(N_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);

  loader_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, idx;
  logic              accept, in_frame;
  logic              wren_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              unused_lsbs;

  assign unused_lsbs = ^s_data;
  assign accept      = s_valid && s_ready;
  assign in_frame    = (state_q == IDLE) || (state_q == LOAD);
  // Beat accepted in IDLE is always pixel 0; the counter only holds meaning in LOAD.
  assign idx         = (state_q == LOAD) ? cnt_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (idx == LAST_IDX) state_d = s_last ? BIAS : DRAIN;
          else if (s_last)     state_d = IDLE;
          else                 state_d = LOAD;
        end
      end
      DRAIN:   if (accept && s_last) state_d = IDLE;
      BIAS:    state_d = HOLD;
      HOLD:    if (infer_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wren_d = 1'b0;
    err_d  = 1'b0;
    addr_d = ram_addr;
    data_d = ram_data;
    cnt_d  = '0;
    if (in_frame && accept) begin
      wren_d = 1'b1;
      addr_d = ADDR_W'(idx);
      data_d = s_data[IN_W-1 -: DATA_W];
      err_d  = (s_last && (idx < LAST_IDX)) || (!s_last && (idx == LAST_IDX));
    end
    if (state_q == BIAS) begin
      wren_d = 1'b1;
      addr_d = ADDR_W'(N_PIX);
      data_d = BIAS_VAL;
    end
    if (state_d == LOAD)
      cnt_d = (in_frame && accept) ? idx + CNT_W'(1) : cnt_q;
  end

  // Outputs are registered from the next state so the handshake and write port change cleanly on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      s_ready   <= 1'b0;
      ram_wren  <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      img_ready <= 1'b0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      cnt_q     <= cnt_d;
      s_ready   <= (state_d == IDLE) || (state_d == LOAD) || (state_d == DRAIN);
      ram_wren  <= wren_d;
      ram_addr  <= addr_d;
      ram_data  <= data_d;
      img_ready <= (state_d == HOLD);
      err_len   <= err_d;
      if (state_q == HOLD && infer_ack) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef LOADER_CKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cksum <= '0;
    else if (state_d == IDLE)  cksum <= '0;
    else if (wren_d)           cksum <= cksum + 16'(data_d);
  end
`endif

endmodule

// File: tb/tb_cnn_input_loader.sv
// Self-checking bench for cnn_input_loader: directed frame scenarios with randomized pixels and valid gaps.
module tb_cnn_input_loader;

  localparam int N = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  s_data;
  logic [11:0] ram_addr;
  logic [6:0]  ram_data;
  logic        ram_wren, img_ready, infer_ack, err_len;
  logic [15:0] frame_cnt;
`ifdef LOADER_CKSUM_EN
  logic [15:0] cksum;
`endif

  cnn_input_loader #(
    .IN_W(8),
    .DATA_W(7),
    .ADDR_W(12),
    .N_PIX(N),
    .BIAS_VAL(7'h40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .ram_addr(ram_addr),
    .ram_data(ram_data),
    .ram_wren(ram_wren),
    .img_ready(img_ready),
    .infer_ack(infer_ack),
    .err_len(err_len),
    .frame_cnt(frame_cnt)
`ifdef LOADER_CKSUM_EN
    ,
    .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int c;
  } wr_t;

  int   cyc = 0;
  wr_t  wq[$];
  int   errq[$];
  int   riseq[$];
  int   acc_c[$];
  int   mem[0:511];
  logic img_prev = 1'b0;
  logic [7:0] pix[0:511];
  int   tests = 0;
  int   fails = 0;
  int   exp_fc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      wq.push_back('{int'(ram_addr), int'(ram_data), cyc});
      if (ram_addr < 12'd512) mem[ram_addr] <= int'(ram_data);
    end
    if (err_len === 1'b1) errq.push_back(cyc);
    if (img_ready === 1'b1 && img_prev !== 1'b1) riseq.push_back(cyc);
    img_prev <= img_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives beats 0..nbeats-1 from pix[]; records the cycle in which each beat is accepted.
  task automatic send(input int nbeats, input int last_at, input bit gappy, input int ack_at);
    int i = 0;
    int guard = 0;
    acc_c.delete();
    while (i < nbeats && guard < 20000) begin
      @(negedge clk);
      guard++;
      s_valid   = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data    = pix[i];
      s_last    = (i == last_at);
      infer_ack = (i == ack_at);
      if (s_valid && s_ready) begin
        acc_c.push_back(cyc);
        i++;
      end
    end
    @(negedge clk);
    s_valid   = 1'b0;
    s_last    = 1'b0;
    infer_ack = 1'b0;
    chk("send_complete", 64'(i), 64'(nbeats));
  endtask

  // kind: 0 exact frame, 1 short frame ending at last_at, 2 long frame
  task automatic check_frame(input string tag, input int kind, input int last_at);
    int nw, bad, eb, ba, bd, bc, ec;
    repeat (2) @(negedge clk);
    #1;
    nw = (kind == 1) ? last_at + 1 : N;
    chk($sformatf("%s_nwrites", tag), 64'(wq.size()), 64'(nw + ((kind == 0) ? 1 : 0)));
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      if (i >= wq.size() || i >= acc_c.size()) bad++;
      else if (wq[i].addr != i || wq[i].data != (int'(pix[i]) >> 1) || wq[i].c != acc_c[i] + 1) bad++;
    end
    chk($sformatf("%s_pix_writes", tag), 64'(bad), 64'd0);
    if (kind == 0) begin
      ba = (wq.size() > nw) ? wq[nw].addr : -1;
      bd = (wq.size() > nw) ? wq[nw].data : -1;
      bc = (wq.size() > nw) ? wq[nw].c : -1;
      chk($sformatf("%s_bias_addr", tag), 64'(ba), 64'(N));
      chk($sformatf("%s_bias_data", tag), 64'(bd), 64'h40);
      chk($sformatf("%s_bias_cycle", tag), 64'(bc), 64'(acc_c[N-1] + 2));
      chk($sformatf("%s_img_ready", tag), 64'(img_ready), 64'd1);
      chk($sformatf("%s_img_rise", tag), 64'((riseq.size() > 0) ? riseq[0] : -1), 64'(acc_c[N-1] + 2));
      chk($sformatf("%s_no_err", tag), 64'(errq.size()), 64'd0);
      chk($sformatf("%s_ready_low", tag), 64'(s_ready), 64'd0);
      bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] != (int'(pix[i]) >> 1)) bad++;
      if (mem[N] != 64) bad++;
      chk($sformatf("%s_ram_image", tag), 64'(bad), 64'd0);
    end else begin
      eb = (kind == 1) ? last_at : N - 1;
      ec = (errq.size() > 0) ? errq[0] : -1;
      chk($sformatf("%s_err_count", tag), 64'(errq.size()), 64'd1);
      chk($sformatf("%s_err_cycle", tag), 64'(ec), 64'((acc_c.size() > eb) ? acc_c[eb] + 1 : -99));
      chk($sformatf("%s_img_low", tag), 64'(img_ready), 64'd0);
      chk($sformatf("%s_img_never", tag), 64'(riseq.size()), 64'd0);
      chk($sformatf("%s_ready_idle", tag), 64'(s_ready), 64'd1);
    end
    wq.delete();
    errq.delete();
    riseq.delete();
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    infer_ack = 1'b1;
    @(negedge clk);
    infer_ack = 1'b0;
    exp_fc++;
    chk($sformatf("%s_frame_cnt", tag), 64'(frame_cnt), 64'(exp_fc));
    chk($sformatf("%s_ready_after_ack", tag), 64'(s_ready), 64'd1);
    chk($sformatf("%s_img_after_ack", tag), 64'(img_ready), 64'd0);
  endtask

  initial begin
    int bad, sum;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; infer_ack = 1'b0;
    for (int i = 0; i < 512; i++) pix[i] = 8'(i % 256);
    #12;
    chk("reset_outputs", 64'({s_ready, ram_wren, img_ready, err_len, ram_addr, ram_data, frame_cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(N, N - 1, 1'b0, -1);
    check_frame("nominal", 0, 0);
    do_ack("nominal");

    for (int i = 0; i < 512; i++) pix[i] = 8'($urandom_range(0, 255));
    send(N, N - 1, 1'b1, -1);
    check_frame("gappy", 0, 0);
    do_ack("gappy");

    send(11, 10, 1'b0, -1);
    check_frame("short", 1, 10);
    send(N, N - 1, 1'b1, -1);
    check_frame("after_short", 0, 0);
    do_ack("after_short");

    send(405, 404, 1'b0, -1);
    check_frame("long", 2, 0);
    chk("long_frame_cnt", 64'(frame_cnt), 64'(exp_fc));

    for (int i = 0; i < 512; i++) pix[i] = 8'(i % 256);
    send(N, N - 1, 1'b0, -1);
    check_frame("hold", 0, 0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      if (s_ready !== 1'b0 || img_ready !== 1'b1) bad++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("hold_backpressure", 64'(bad), 64'd0);
    chk("hold_no_writes", 64'(wq.size()), 64'd0);
    do_ack("hold");

    send(N, N - 1, 1'b1, 100);
    check_frame("ack_in_load", 0, 0);
    chk("ack_in_load_cnt", 64'(frame_cnt), 64'(exp_fc));
    do_ack("ack_in_load");

    for (int i = 0; i < 512; i++) pix[i] = 8'($urandom_range(0, 255));
    send(201, -1, 1'b0, -1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({s_ready, ram_wren, img_ready, err_len, ram_addr, ram_data, frame_cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    wq.delete(); errq.delete(); riseq.delete();
    exp_fc = 0;
    send(N, N - 1, 1'b1, -1);
    check_frame("post_reset", 0, 0);
    sum = 64;
    for (int i = 0; i < N; i++) sum += int'(pix[i]) >> 1;
`ifdef LOADER_CKSUM_EN
    chk("cksum", 64'(cksum), 64'(sum & 16'hFFFF));
`endif
    do_ack("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnn_input_loader.md
Name: cnn_input_loader

Overview:
Writer side of the CNN input-feature RAM. Accepts an 8-bit pixel stream on a valid/ready handshake and quantizes each pixel to 7 bits. Writes pixels into the input RAM write port at addresses 0..N_PIX-1, then writes the constant bias word at address N_PIX. Signals the inference engine that a full image (N_PIX+1 words) is resident, and holds off new pixels until the engine acknowledges.

Parameters:
IN_W, 8, stream pixel width
DATA_W, 7, RAM word width; must satisfy DATA_W <= IN_W
ADDR_W, 12, RAM address width
N_PIX, 400, pixels per image; the bias word lives at address N_PIX
BIAS_VAL, 7'h40, value written at address N_PIX (1.0 in the Q-format used by layer 1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  pixel beat valid
s_data  in  IN_W  pixel value, unsigned
s_last  in  1  marks final pixel of a frame
s_ready  out  1  loader can accept a beat
ram_addr  out  ADDR_W  input RAM write address
ram_data  out  DATA_W  input RAM write data
ram_wren  out  1  input RAM write enable
img_ready  out  1  level; full image resident, engine may start
infer_ack  in  1  one-cycle pulse; engine finished reading input RAM
err_len  out  1  one-cycle pulse on a malformed frame length
frame_cnt  out  16  images successfully handed to the engine, wraps at 2^16

Behaviour:
- Reset values: s_ready=0, ram_addr=0, ram_data=0, ram_wren=0, img_ready=0, err_len=0, frame_cnt=0, state=IDLE, beat counter=0.
- A beat is accepted when s_valid && s_ready.
- State IDLE: s_ready=1. The first accepted beat is pixel 0; go to LOAD.
- State LOAD: s_ready=1. Each accepted beat increments the beat counter.
- Quantization: ram_data = s_data[IN_W-1 -: DATA_W], i.e. truncate LSBs with no rounding.
- Write latency is exactly 1 cycle: on the cycle after an accept, ram_wren=1, ram_addr=beat index, ram_data=quantized pixel. Otherwise ram_wren=0. Back-to-back accepts give back-to-back writes.
- Short frame: s_last accepted on beat index < N_PIX-1. Pulse err_len, return to IDLE, do not raise img_ready. Words already written are left stale and are overwritten by the next frame.
- Exact frame: beat N_PIX-1 accepted with s_last=1. Go to BIAS.
- Long frame: beat N_PIX-1 accepted with s_last=0. Pulse err_len and go to DRAIN.
- State DRAIN: s_ready=1. Accepted beats are discarded with no writes. On accepting s_last, return to IDLE.
- State BIAS: s_ready=0. For one cycle, write BIAS_VAL at address N_PIX. Next state HOLD.
- State HOLD: s_ready=0, img_ready=1.
  - On infer_ack: clear img_ready, increment frame_cnt, go to IDLE. s_ready goes to 1 on the following cycle.
- infer_ack outside HOLD is ignored.
- A single-beat frame (s_last on beat 0) counts as a short frame, unless N_PIX=1.
- Reset mid-operation: everything returns to reset values within the same clock cycle that rst rises (asynchronous). The partial image is discarded and img_ready drops immediately.
- Beat counter width: ceil(log2(N_PIX+1)). No wrap occurs inside a frame, because the LOAD exit is forced at N_PIX-1.

Optional Feature:
LOADER_CKSUM_EN
- When defined:
  - Adds an output port cksum[15:0]: the modulo-2^16 sum of all DATA_W words written for the current image, including the bias word.
  - The sum clears on entry to IDLE and is stable while img_ready=1.
  - Reset value is 0.
- When undefined: the port, the adder and the register are absent. All other behaviour is identical.

Decomposition:
- Shared package cnn_pkg holds:
  - constants CNN_DATA_W=7, CNN_ADDR_W=12, CNN_N_PIX=400, CNN_BIAS_VAL;
  - loader state enum {IDLE, LOAD, BIAS, HOLD, DRAIN}.
- The inference engine uses the same constants for its read counters.
- No sub-module: the quantizer is a single slice, and the FSM plus counters fit in one module.

Test Plan:
- Nominal frame: stream pixels p[i]=i mod 256, s_valid=1 throughout, s_last on beat 399.
  - Required: 400 writes with addr=i and data=p[i]>>1, then addr 400 with data 7'h40.
  - img_ready rises 2 cycles after the last accept.
  - infer_ack pulse -> frame_cnt=1, s_ready=1 on the next cycle.
- Gappy stream: s_valid toggled randomly at 50%.
  - Required: writes occur only the cycle after each accept; final RAM image identical to the nominal frame.
- Short frame: s_last on beat 10.
  - Required: err_len single pulse, no bias write, img_ready stays 0.
  - A following nominal frame loads correctly and frame_cnt becomes 1.
- Long frame: 405 beats with s_last on beat 404.
  - Required: err_len pulse on the cycle after beat 399 is accepted; beats 400..404 produce no writes; state returns to IDLE; img_ready=0.
- Backpressure and ack: in HOLD, drive s_valid=1 for 50 cycles, then pulse infer_ack.
  - Required: s_ready=0 for all 50 cycles, no writes, no beats lost.
  - A second frame then loads and frame_cnt=2.
  - infer_ack pulsed while in LOAD has no effect.
- Reset mid-LOAD: assert rst after beat 200.
  - Required: all outputs 0 asynchronously.
  - After release, a full frame loads correctly.
  - With LOADER_CKSUM_EN defined, cksum equals the sum of the 400 quantized pixels plus 0x40.
